// File: rtl/xgxs_pcs_pkg.sv
// ============================================================================
// xgxs_pcs_pkg : shared XGXS PCS code-group constants, lane type, lane mapper
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

package xgxs_pcs_pkg;

  localparam logic [7:0] K28_0      = 8'h1C;  // ||R||
  localparam logic [7:0] K28_3      = 8'h7C;  // ||A||
  localparam logic [7:0] K28_4      = 8'h9C;  // ||Q||
  localparam logic [7:0] K28_5      = 8'hBC;  // ||K||
  localparam logic [7:0] K27_7      = 8'hFB;  // /S/
  localparam logic [7:0] K29_7      = 8'hFD;  // /T/
  localparam logic [7:0] K30_7      = 8'hFE;  // /E/
  localparam logic [7:0] XGMII_IDLE = 8'h07;

  localparam logic [4:0] A_SPACING_BASE = 5'd16;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
  } lane_slice_t;

  // Translation of one lane inside a non-idle column.
  function automatic lane_slice_t map_lane(input logic [7:0] b, input logic c,
                                           input logic sel_r);
    lane_slice_t s;
    s.data = b;
    s.k    = 1'b0;
    if (c) begin
      s.k = 1'b1;
      case (b)
        K27_7, K29_7, K30_7: s.data = b;
        XGMII_IDLE:          s.data = sel_r ? K28_0 : K28_5;
        default:             s.data = K30_7;
      endcase
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xgxs_tx_idle_gen.sv
// ============================================================================
// xgxs_tx_idle_gen : idle PRBS (x^7+x^6+1) and ||A|| spacing counter
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module xgxs_tx_idle_gen
  import xgxs_pcs_pkg::*;
#(
  parameter logic [6:0] LFSR_SEED = 7'h7F
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_col,
  output logic send_a,
  output logic sel_r
);

  logic [6:0] prbs_q, prbs_d;
  logic [4:0] a_cnt_q, a_cnt_d;
  logic       w_reload;

  assign send_a   = (a_cnt_q == 5'd0);
  assign sel_r    = prbs_q[0];
  assign w_reload = idle_col & send_a;

  // Reload sees the pre-shift PRBS; an ||A|| due in a data column just waits at zero.
  always_comb begin
    prbs_d  = {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};
    a_cnt_d = a_cnt_q;
    if (w_reload) begin
      a_cnt_d = A_SPACING_BASE + {1'b0, prbs_q[3:0]};
    end else if (a_cnt_q != 5'd0) begin
      a_cnt_d = a_cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prbs_q  <= LFSR_SEED;
      a_cnt_q <= 5'd0;
    end else begin
      prbs_q  <= prbs_d;
      a_cnt_q <= a_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/xgxs_tx_mapper.sv
// ============================================================================
// xgxs_tx_mapper : XGMII column to four 8b/10b lane inputs with idle randomizing
// Revision       : 1.0  initial release; XGXS_TX_SEQ_EN enables ||Q|| pass-through
// ============================================================================
`default_nettype none

module xgxs_tx_mapper
  import xgxs_pcs_pkg::*;
#(
  parameter logic [6:0] LFSR_SEED = 7'h7F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] txd,
  input  logic [3:0]  txc,
  output logic [31:0] lane_data_out,
  output logic [3:0]  lane_konstant_out,
  output logic        col_is_idle
);

  logic        w_send_a;
  logic        w_sel_r;
  logic        w_idle_pat;
  logic        w_q_pat;
  logic        w_is_idle;
  logic        w_pass_q;
  lane_slice_t w_lane [4];

  logic [31:0] data_q, data_d;
  logic [3:0]  konst_q, konst_d;
  logic        idle_q, idle_d;

  assign w_idle_pat = (txc == 4'hF) && (txd == {4{XGMII_IDLE}});
  assign w_q_pat    = (txc == 4'b0001) && (txd[7:0] == K28_4);

`ifdef XGXS_TX_SEQ_EN
  assign w_is_idle = w_idle_pat;
  assign w_pass_q  = w_q_pat;
`else
  assign w_is_idle = w_idle_pat | w_q_pat;
  assign w_pass_q  = 1'b0;
`endif

  xgxs_tx_idle_gen #(
    .LFSR_SEED (LFSR_SEED)
  ) u_idle_gen (
    .clk      (clk),
    .rst      (rst),
    .idle_col (w_is_idle),
    .send_a   (w_send_a),
    .sel_r    (w_sel_r)
  );

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = map_lane(txd[8*gi +: 8], txc[gi], w_sel_r);
  end

  always_comb begin
    data_d  = '0;
    konst_d = 4'hF;
    idle_d  = w_is_idle;
    if (w_is_idle) begin
      if (w_send_a)     data_d = {4{K28_3}};
      else if (w_sel_r) data_d = {4{K28_0}};
      else              data_d = {4{K28_5}};
    end else begin
      for (int n = 0; n < 4; n++) begin
        data_d[8*n +: 8] = w_lane[n].data;
        konst_d[n]       = w_lane[n].k;
      end
      if (w_pass_q) begin
        data_d[7:0] = K28_4;
        konst_d[0]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= {4{K28_5}};
      konst_q <= 4'hF;
      idle_q  <= 1'b1;
    end else begin
      data_q  <= data_d;
      konst_q <= konst_d;
      idle_q  <= idle_d;
    end
  end

  assign lane_data_out     = data_q;
  assign lane_konstant_out = konst_q;
  assign col_is_idle       = idle_q;

endmodule

`default_nettype wire

// File: tb/tb_xgxs_tx_mapper.sv
// ============================================================================
// tb_xgxs_tx_mapper : scoreboard bench for xgxs_tx_mapper (honours XGXS_TX_SEQ_EN)
// Revision          : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xgxs_tx_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] txd;
  logic [3:0]  txc;
  logic [31:0] lane_data_out;
  logic [3:0]  lane_konstant_out;
  logic        col_is_idle;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        idle;
  } exp_t;

  exp_t sb[$];
  int   a_idx[$];
  int   total = 0;
  int   bad = 0;
  int   col_idx = 0;

  logic [6:0] m_prbs;
  logic [4:0] m_acnt;

  localparam logic [31:0] IDLE_COL = 32'h07070707;

  always #5 clk = ~clk;

  xgxs_tx_mapper #(.LFSR_SEED(7'h7F)) dut (
    .clk               (clk),
    .rst               (rst),
    .txd               (txd),
    .txc               (txc),
    .lane_data_out     (lane_data_out),
    .lane_konstant_out (lane_konstant_out),
    .col_is_idle       (col_is_idle)
  );

  // Reference model: one call per accepted column.
  task automatic model_step(input logic [31:0] d, input logic [3:0] c, output exp_t e);
    logic [7:0] kr;
    logic [7:0] b;
    logic       idle;
    kr   = m_prbs[0] ? 8'h1C : 8'hBC;
    idle = (c == 4'hF) && (d == IDLE_COL);
`ifndef XGXS_TX_SEQ_EN
    if (c == 4'b0001 && d[7:0] == 8'h9C) idle = 1'b1;
`endif
    e.k    = 4'hF;
    e.idle = idle;
    e.d    = '0;
    if (idle) begin
      if (m_acnt == 5'd0) begin
        e.d    = 32'h7C7C7C7C;
        m_acnt = 5'd16 + {1'b0, m_prbs[3:0]};
      end else begin
        e.d    = {kr, kr, kr, kr};
        m_acnt = m_acnt - 5'd1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        b = d[8*i +: 8];
        if (!c[i]) begin
          e.d[8*i +: 8] = b;
          e.k[i]        = 1'b0;
        end else if (b == 8'hFB || b == 8'hFD || b == 8'hFE) begin
          e.d[8*i +: 8] = b;
        end else if (b == 8'h07) begin
          e.d[8*i +: 8] = kr;
        end else begin
          e.d[8*i +: 8] = 8'hFE;
`ifdef XGXS_TX_SEQ_EN
          if (i == 0 && c == 4'b0001 && b == 8'h9C) e.d[7:0] = 8'h9C;
`endif
        end
      end
      if (m_acnt != 5'd0) m_acnt = m_acnt - 5'd1;
    end
    m_prbs = {m_prbs[5:0], m_prbs[6] ^ m_prbs[5]};
  endtask

  // Drive a column (caller is just past a falling edge), expect the model result.
  task automatic send(input logic [31:0] d, input logic [3:0] c);
    exp_t e;
    txd = d;
    txc = c;
    model_step(d, c, e);
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Same, but with a hand-computed expectation.
  task automatic send_exp(input logic [31:0] d, input logic [3:0] c,
                          input logic [31:0] ed, input logic [3:0] ek, input logic ei);
    exp_t e;
    txd = d;
    txc = c;
    model_step(d, c, e);
    e.d    = ed;
    e.k    = ek;
    e.idle = ei;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    total++;
    if (lane_data_out !== 32'hBCBCBCBC || lane_konstant_out !== 4'hF || col_is_idle !== 1'b1) begin
      bad++;
      $display("FAIL %s: got d=%h k=%h idle=%b, want d=bcbcbcbc k=f idle=1",
               name, lane_data_out, lane_konstant_out, col_is_idle);
    end
  endtask

  // Monitor: one output column per accepted input column, one edge later.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if ({lane_data_out, lane_konstant_out, col_is_idle} !== e) begin
        bad++;
        $display("FAIL col%0d: got d=%h k=%h idle=%b, want d=%h k=%h idle=%b",
                 col_idx, lane_data_out, lane_konstant_out, col_is_idle, e.d, e.k, e.idle);
      end
      if (lane_data_out === 32'h7C7C7C7C && col_is_idle === 1'b1) a_idx.push_back(col_idx);
      col_idx++;
    end
  end

  initial begin
    int gap;
    rst    = 1'b1;
    txd    = '0;
    txc    = '0;
    m_prbs = 7'h7F;
    m_acnt = 5'd0;

    repeat (3) @(posedge clk);
    #1 check_reset("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    send_exp(IDLE_COL, 4'hF, 32'h7C7C7C7C, 4'hF, 1'b1);
    send_exp(32'h555555FB, 4'b0001, 32'h555555FB, 4'b0001, 1'b0);
    send(IDLE_COL, 4'hF);
    send(32'h0707FD55, 4'b1110);
    send_exp(32'h00003C00, 4'b0010, 32'h0000FE00, 4'b0010, 1'b0);
    send_exp(32'h00009C00, 4'b0010, 32'h0000FE00, 4'b0010, 1'b0);
    send_exp(32'hFEFDFB11, 4'b1110, 32'hFEFDFB11, 4'b1110, 1'b0);
`ifdef XGXS_TX_SEQ_EN
    send_exp(32'h0100009C, 4'b0001, 32'h0100009C, 4'b0001, 1'b0);
`else
    send(32'h0100009C, 4'b0001);
`endif
    send(32'h07070707, 4'b0110);

    // 40 data columns drain a_cnt to zero; the deferred ||A|| lands on the next idle.
    for (int i = 0; i < 40; i++) send(32'h01020304 + i, 4'b0000);
    send_exp(IDLE_COL, 4'hF, 32'h7C7C7C7C, 4'hF, 1'b1);

    a_idx.delete();
    for (int i = 0; i < 200; i++) send(IDLE_COL, 4'hF);
    total++;
    if (a_idx.size() < 6) begin
      bad++;
      $display("FAIL a_count: got %0d A columns, want at least 6", a_idx.size());
    end
    for (int i = 1; i < a_idx.size(); i++) begin
      gap = a_idx[i] - a_idx[i-1];
      total++;
      if (gap < 17 || gap > 32) begin
        bad++;
        $display("FAIL a_spacing: got gap %0d, want 17..32", gap);
      end
    end

    // Reset mid-packet: the in-flight column is discarded.
    send(32'hAABBCCFB, 4'b0001);
    rst = 1'b1;
    txd = 32'h11223344;
    txc = 4'b0000;
    m_prbs = 7'h7F;
    m_acnt = 5'd0;
    @(negedge clk);
    check_reset("reset_mid");
    rst = 1'b0;
    send_exp(IDLE_COL, 4'hF, 32'h7C7C7C7C, 4'hF, 1'b1);
    send(IDLE_COL, 4'hF);
    send(32'h070707FD, 4'b1111);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
